// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared FSM state type, bus direction constants and the
// cache-line base helper used by the system-side memory controller.
package sys_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RBURST,
        WCOMMIT,
        TURN
    } sys_state_t;

    localparam logic SYS_READ  = 1'b0;
    localparam logic SYS_WRITE = 1'b1;

    // Clears the low log2(line_words) bits of a word index.
    function automatic logic [31:0] line_base(
        input logic [31:0] idx,
        input int unsigned line_words
    );
        return idx & ~(line_words - 32'd1);
    endfunction

endpackage

// File: rtl/sys_mem_array.sv
// sys_mem_array: word-addressed backing store, one synchronous write port
// and one combinational read port. Contents are never reset.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port.
module sys_mem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sys_mem_ctrl.sv
// sys_mem_ctrl: system-side main-memory controller. Serves line-fill bursts
// and write-through stores on the Sys* bus with programmable wait states.
// Ports: clk, rst (sync, active high); SysStrobe/SysRW/SysAddress/SysDataIn
// request side; SysDataOut/SysDataOe/SysReady/SysBusy/SysErr response side.
module sys_mem_ctrl
    import sys_bus_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int LINE_WORDS  = 4,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SysStrobe,
    input  logic              SysRW,
    input  logic [DATA_W-1:0] SysAddress,
    input  logic [DATA_W-1:0] SysDataIn,
    output logic [DATA_W-1:0] SysDataOut,
    output logic              SysDataOe,
    output logic              SysReady,
    output logic              SysBusy,
    output logic              SysErr
);

    localparam int BW = $clog2(LINE_WORDS);

    // Last value of the wait counter before leaving WAIT.
    localparam logic [3:0] WLAST =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [BW-1:0] BLAST = BW'(LINE_WORDS - 1);

    sys_state_t        r_state;
    sys_state_t        w_next;

    logic              r_rw;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;
    logic [3:0]        r_wcnt;
    logic [BW-1:0]     r_beat;

    logic [ADDR_W-1:0] w_idx;
    logic              w_oor;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_we;

    // Byte-lane bits carry no meaning for a word-wide store.
    logic              w_unused_lsb;

    assign w_unused_lsb = &{1'b1, SysAddress[1:0]};

    assign w_idx = SysAddress[ADDR_W+1:2];
    assign w_oor = |SysAddress[DATA_W-1:ADDR_W+2];

    assign w_base  = ADDR_W'(line_base(32'(r_idx), LINE_WORDS));
    // Base has its low BW bits clear, so OR-ing the beat never carries.
    assign w_raddr = w_base | ADDR_W'(r_beat);

    sys_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rw    <= SYS_READ;
            r_idx   <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_wcnt  <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (SysStrobe) begin
                        r_rw    <= SysRW;
                        r_idx   <= w_idx;
                        r_wdata <= SysDataIn;
                        r_err   <= w_oor;
                        r_wcnt  <= '0;
                        r_beat  <= '0;
                    end
                end
                WAIT: begin
                    r_wcnt <= r_wcnt + 4'd1;
                end
                RBURST: begin
                    r_beat <= r_beat + BW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        w_we       = 1'b0;
        SysDataOut = '0;
        SysDataOe  = 1'b0;
        SysReady   = 1'b0;
        SysErr     = 1'b0;
        SysBusy    = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (SysStrobe) begin
                    // With no wait states the access starts next cycle.
                    if (WAIT_CYCLES == 0) begin
                        w_next = (SysRW == SYS_WRITE) ? WCOMMIT : RBURST;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_wcnt == WLAST) begin
                    w_next = (r_rw == SYS_WRITE) ? WCOMMIT : RBURST;
                end
            end
            RBURST: begin
                SysDataOe  = 1'b1;
                SysReady   = 1'b1;
                SysErr     = r_err;
                SysDataOut = r_err ? '0 : w_rdata;
                if (r_beat == BLAST) begin
                    w_next = TURN;
                end
            end
            WCOMMIT: begin
                SysReady = 1'b1;
                SysErr   = r_err;
                w_we     = ~r_err;
                w_next   = TURN;
            end
            TURN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sys_mem_ctrl.sv
// tb_sys_mem_ctrl: randomized self-checking bench for sys_mem_ctrl.
// Two instances: unit 0 with 3 wait states, unit 1 with none.
module tb_sys_mem_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  strobe = '0;
    logic [1:0]  rw = '0;
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic [1:0]  oe;
    logic [1:0]  ready;
    logic [1:0]  busy;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl   [2][1024];
    bit          known [2][1024];

    always #5 clk = ~clk;

    sys_mem_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .LINE_WORDS(LW), .WAIT_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst),
        .SysStrobe(strobe[0]), .SysRW(rw[0]),
        .SysAddress(addr[0]), .SysDataIn(din[0]),
        .SysDataOut(dout[0]), .SysDataOe(oe[0]),
        .SysReady(ready[0]), .SysBusy(busy[0]), .SysErr(err[0])
    );

    sys_mem_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .LINE_WORDS(LW), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .SysStrobe(strobe[1]), .SysRW(rw[1]),
        .SysAddress(addr[1]), .SysDataIn(din[1]),
        .SysDataOut(dout[1]), .SysDataOe(oe[1]),
        .SysReady(ready[1]), .SysBusy(busy[1]), .SysErr(err[1])
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int u);
        int n = 0;
        while (busy[u] !== 1'b0 && n < 50) begin
            cyc();
            n++;
        end
        checks++;
        if (busy[u] !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout u%0d busy=%b want 0", u, busy[u]);
        end
    endtask

    // One request, checked every cycle against the latency rules.
    task automatic xact(input int u, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
        int wc   = (u == 0) ? 3 : 0;
        int idx  = int'(a[11:2]);
        bit oor  = (a[31:12] != 20'd0);
        int base = idx & ~(LW - 1);
        int last = wr ? 1 + wc : wc + LW;
        bit rdy;
        bit chk_d;
        int w;
        logic [3:0]  exp_f;
        logic [3:0]  got_f;
        logic [31:0] exp_d;
        wait_idle(u);
        strobe[u] = 1'b1;
        rw[u]     = wr;
        addr[u]   = a;
        din[u]    = d;
        cyc();
        if (!hold) begin
            strobe[u] = 1'b0;
            rw[u]     = 1'($urandom);
            addr[u]   = $urandom;
            din[u]    = $urandom;
        end
        for (int k = 1; k <= last + 1; k++) begin
            rdy   = wr ? (k == 1 + wc) : (k >= 1 + wc && k <= last);
            exp_f = {rdy, rdy && !wr, rdy && oor, 1'b1};
            got_f = {ready[u], oe[u], err[u], busy[u]};
            exp_d = '0;
            chk_d = 1'b1;
            if (rdy && !wr && !oor) begin
                w     = base + k - 1 - wc;
                exp_d = mdl[u][w];
                chk_d = known[u][w];
            end
            checks++;
            if (got_f !== exp_f || (chk_d && dout[u] !== exp_d)) begin
                errors++;
                $display("FAIL %s u%0d a=%h cyc%0d rdy/oe/err/busy=%b want %b data=%h want %h",
                         wr ? "write" : "read", u, a, k, got_f, exp_f,
                         dout[u], exp_d);
            end
            cyc();
        end
        checks++;
        if ({ready[u], oe[u], busy[u], err[u]} !== 4'b0000 || dout[u] !== '0) begin
            errors++;
            $display("FAIL end_idle u%0d rdy/oe/busy/err=%b want 0000 data=%h",
                     u, {ready[u], oe[u], busy[u], err[u]}, dout[u]);
        end
        if (wr && !oor) begin
            mdl[u][idx]   = d;
            known[u][idx] = 1'b1;
        end
    endtask

    task automatic check_quiet(input string name);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({ready[u], oe[u], busy[u], err[u]} !== 4'b0000 || dout[u] !== '0) begin
                errors++;
                $display("FAIL %s u%0d rdy/oe/busy/err=%b want 0000 data=%h want 0",
                         name, u, {ready[u], oe[u], busy[u], err[u]}, dout[u]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_quiet("reset_idle");
        end
    endtask

    task automatic test_prefill();
        for (int i = 0; i < 64; i++) begin
            xact(0, 1'b1, 32'(i * 4), $urandom, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            xact(1, 1'b1, 32'(i * 4), $urandom, 1'b0);
        end
    endtask

    task automatic test_line_order();
        for (int i = 0; i < 4; i++) begin
            xact(0, 1'b1, 32'(16 + i * 4), 32'hA0 + 32'(i), 1'b0);
        end
        xact(0, 1'b0, 32'h14, 32'h0, 1'b0);
        xact(0, 1'b0, 32'h1F, 32'h0, 1'b0);
    endtask

    task automatic test_write_read();
        xact(0, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0);
        xact(0, 1'b0, 32'h20, 32'h0, 1'b0);
    endtask

    task automatic test_out_of_range();
        xact(0, 1'b0, 32'h0000_1000, 32'h0, 1'b0);
        xact(0, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0);
        xact(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
        xact(0, 1'b1, 32'h8000_0024, 32'hCAFE_F00D, 1'b0);
        xact(0, 1'b0, 32'h0000_0024, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        wait_idle(0);
        strobe[0] = 1'b1;
        rw[0]     = 1'b0;
        addr[0]   = 32'h14;
        repeat (6) cyc();
        checks++;
        if (ready[0] !== 1'b1 || dout[0] !== mdl[0][6]) begin
            errors++;
            $display("FAIL beat2_pre_rst ready=%b data=%h want 1 %h",
                     ready[0], dout[0], mdl[0][6]);
        end
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check_quiet("mid_reset");
        end
        rst = 1'b0;
        xact(0, 1'b0, 32'h14, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        xact(0, 1'b0, 32'h30, 32'h0, 1'b1);
        xact(0, 1'b0, 32'h30, 32'h0, 1'b0);
        xact(1, 1'b0, 32'h00, 32'h0, 1'b0);
        xact(1, 1'b0, 32'h10, 32'h0, 1'b1);
        xact(1, 1'b0, 32'h10, 32'h0, 1'b0);
        xact(1, 1'b1, 32'h08, 32'h5A5A_0001, 1'b0);
        xact(1, 1'b0, 32'h08, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit wr;
        int u;
        for (int i = 0; i < 60; i++) begin
            u  = (i % 3 == 2) ? 1 : 0;
            wr = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                a = (32'($urandom_range(1, 20'hFFFFF)) << 12)
                    | ($urandom & 32'hFFF);
            end else begin
                a = (32'($urandom_range(0, 63)) << 2) | ($urandom & 32'h3);
            end
            xact(u, wr, a, $urandom, 1'b0);
        end
    endtask

    initial begin
        addr[0] = '0;
        addr[1] = '0;
        din[0]  = '0;
        din[1]  = '0;
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 1024; i++) begin
                known[u][i] = 1'b0;
                mdl[u][i]   = '0;
            end
        end
        cyc();
        test_reset();
        test_prefill();
        test_line_order();
        test_write_read();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
